pulse_voice_bank: RTL and testbench



---
 rtl/acp_tone_pkg.sv | 42 ++++
 rtl/pulse_voice_bank_if.sv | 29 ++
 rtl/tone_inc_calc.sv | 33 +++
 rtl/pulse_voice_bank.sv | 157 +++++++++++++++
 tb/tb_pulse_voice_bank.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acp_tone_pkg.sv
// Shared constants for the pulse voice bank: note-to-increment mapping,
// duty thresholds and the rest note encoding.
package acp_tone_pkg;

  localparam int  NOTE_REST = 0;
  localparam real F_SYS_HZ  = 50.0e6;
  localparam real F_BASE_HZ = 55.0;

  typedef enum logic [1:0] {
    DUTY_12P5 = 2'b00,
    DUTY_25   = 2'b01,
    DUTY_50   = 2'b10,
    DUTY_75   = 2'b11
  } duty_e;

  // Compared against the top three accumulator bits, so each unit is 1/8 of a period.
  localparam logic [2:0] THR_12P5 = 3'd1;
  localparam logic [2:0] THR_25   = 3'd2;
  localparam logic [2:0] THR_50   = 3'd4;
  localparam logic [2:0] THR_75   = 3'd6;

  function automatic logic [2:0] duty_thresh(input logic [1:0] duty);
    case (duty)
      DUTY_12P5: duty_thresh = THR_12P5;
      DUTY_25:   duty_thresh = THR_25;
      DUTY_50:   duty_thresh = THR_50;
      default:   duty_thresh = THR_75;
    endcase
  endfunction

  // Elaboration-time only: equal-tempered pitch from A1 = 55 Hz, scaled to the
  // per-channel update rate (system clock divided by the slot count).
  function automatic int note_inc(input int note, input int num_ch, input int acc_w);
    real f_hz;
    real f_upd;
    if (note == NOTE_REST) return 0;
    f_hz  = F_BASE_HZ * (2.0 ** (real'(note - 1) / 12.0));
    f_upd = F_SYS_HZ / real'(num_ch);
    return $rtoi(f_hz * (2.0 ** acc_w) / f_upd + 0.5);
  endfunction

endpackage

// File: rtl/pulse_voice_bank_if.sv
// Settings bus into the voice bank and the pulse/mix outputs back out.
interface pulse_voice_bank_if #(
    parameter int NUM_CH = 4,
    parameter int NOTE_W = 6,
    parameter int OFFS_W = 3
);
    localparam int MIX_W = $clog2(NUM_CH + 1);

    logic [NUM_CH*NOTE_W-1:0] note_in;
    logic [NUM_CH*OFFS_W-1:0] offset_mult;
    logic [NUM_CH-1:0]        offset_dir;
    logic [NUM_CH*2-1:0]      duty_sel;
    logic [NUM_CH-1:0]        ch_en;
    logic                     load;
    logic [NUM_CH-1:0]        wave_out;
    logic [MIX_W-1:0]         mix_out;

    // load is a one-cycle strobe with no ready: every clock edge that sees it
    // high captures all setting fields; ch_en is level-sensitive, not handshaked.
    modport master (
        output note_in, offset_mult, offset_dir, duty_sel, ch_en, load,
        input  wave_out, mix_out
    );

    modport slave (
        input  note_in, offset_mult, offset_dir, duty_sel, ch_en, load,
        output wave_out, mix_out
    );
endinterface

// File: rtl/tone_inc_calc.sv
// Shared increment calculator: note ROM lookup followed by a detune of
// (inc >> 7) * mult, added or subtracted.
module tone_inc_calc
    import acp_tone_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int NOTE_W = 6,
    parameter int ACC_W  = 24,
    parameter int OFFS_W = 3
) (
    input  logic [NOTE_W-1:0] note_i,
    input  logic [OFFS_W-1:0] mult_i,
    input  logic              dir_i,
    output logic [ACC_W-1:0]  inc_o
);
    localparam int ROM_DEPTH = 2 ** NOTE_W;

    logic [ACC_W-1:0] rom [ROM_DEPTH];
    logic [ACC_W-1:0] base_inc;
    logic [ACC_W-1:0] step_inc;

    for (genvar n = 0; n < ROM_DEPTH; n++) begin : g_rom
        localparam logic [ACC_W-1:0] INC = ACC_W'(note_inc(n, NUM_CH, ACC_W));
        assign rom[n] = INC;
    end

    // ROM peak stays below 2^(ACC_W-2), so neither direction can wrap.
    always_comb begin
        base_inc = rom[note_i];
        step_inc = (base_inc >> 7) * ACC_W'(mult_i);
        inc_o    = dir_i ? (base_inc - step_inc) : (base_inc + step_inc);
    end
endmodule

// File: rtl/pulse_voice_bank.sv
// Time-multiplexed pulse voice bank: one accumulator update per slot,
// two-stage pipeline, wrap-synchronous setting transfer and a popcount mixer.
module pulse_voice_bank
    import acp_tone_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int NOTE_W = 6,
    parameter int ACC_W  = 24,
    parameter int OFFS_W = 3
) (
    input  logic              clk50mhz,
    input  logic              rst,
    pulse_voice_bank_if.slave bus
);
    localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MIX_W  = $clog2(NUM_CH + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    logic [SLOT_W-1:0] slot_q, slot_d;

    logic [NOTE_W-1:0] pend_note_q [NUM_CH];
    logic [NOTE_W-1:0] pend_note_d [NUM_CH];
    logic [OFFS_W-1:0] pend_mult_q [NUM_CH];
    logic [OFFS_W-1:0] pend_mult_d [NUM_CH];
    logic [1:0]        pend_duty_q [NUM_CH];
    logic [1:0]        pend_duty_d [NUM_CH];
    logic [NUM_CH-1:0] pend_dir_q, pend_dir_d;

    logic [NOTE_W-1:0] act_note_q [NUM_CH];
    logic [NOTE_W-1:0] act_note_d [NUM_CH];
    logic [OFFS_W-1:0] act_mult_q [NUM_CH];
    logic [OFFS_W-1:0] act_mult_d [NUM_CH];
    logic [1:0]        act_duty_q [NUM_CH];
    logic [1:0]        act_duty_d [NUM_CH];
    logic [NUM_CH-1:0] act_dir_q, act_dir_d;

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];

    logic              s1_vld_q;
    logic [SLOT_W-1:0] s1_ch_q;
    logic [ACC_W-1:0]  s1_inc_q;
    logic [2:0]        s1_thr_q;
    logic              s1_rest_q;

    logic [NUM_CH-1:0] wave_q, wave_d;
    logic [MIX_W-1:0]  mix_q;

    logic [ACC_W-1:0]  inc_adj;
    logic [ACC_W:0]    sum;
    logic              xfer;

    assign slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;

    tone_inc_calc #(
        .NUM_CH (NUM_CH),
        .NOTE_W (NOTE_W),
        .ACC_W  (ACC_W),
        .OFFS_W (OFFS_W)
    ) u_inc (
        .note_i (act_note_q[slot_q]),
        .mult_i (act_mult_q[slot_q]),
        .dir_i  (act_dir_q[slot_q]),
        .inc_o  (inc_adj)
    );

    // Stage 2: accumulate the registered slot; pending settings only move to
    // active at a wrap, while disabled, or while resting, so pulses never runt.
    always_comb begin
        pend_note_d = pend_note_q;
        pend_mult_d = pend_mult_q;
        pend_duty_d = pend_duty_q;
        pend_dir_d  = pend_dir_q;
        act_note_d  = act_note_q;
        act_mult_d  = act_mult_q;
        act_duty_d  = act_duty_q;
        act_dir_d   = act_dir_q;
        acc_d       = acc_q;
        wave_d      = wave_q;
        xfer        = 1'b0;
        sum         = {1'b0, acc_q[s1_ch_q]} + {1'b0, s1_inc_q};

        if (bus.load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pend_note_d[k] = bus.note_in[k*NOTE_W +: NOTE_W];
                pend_mult_d[k] = bus.offset_mult[k*OFFS_W +: OFFS_W];
                pend_duty_d[k] = bus.duty_sel[k*2 +: 2];
                pend_dir_d[k]  = bus.offset_dir[k];
            end
        end

        if (s1_vld_q) begin
            if (!bus.ch_en[s1_ch_q]) begin
                acc_d[s1_ch_q]  = '0;
                wave_d[s1_ch_q] = 1'b0;
                xfer            = 1'b1;
            end else if (s1_rest_q) begin
                wave_d[s1_ch_q] = 1'b0;
                xfer            = 1'b1;
            end else begin
                acc_d[s1_ch_q]  = sum[ACC_W-1:0];
                wave_d[s1_ch_q] = (sum[ACC_W-1 -: 3] < s1_thr_q);
                xfer            = sum[ACC_W];
            end
        end

        if (xfer) begin
            act_note_d[s1_ch_q] = pend_note_d[s1_ch_q];
            act_mult_d[s1_ch_q] = pend_mult_d[s1_ch_q];
            act_duty_d[s1_ch_q] = pend_duty_d[s1_ch_q];
            act_dir_d[s1_ch_q]  = pend_dir_d[s1_ch_q];
        end
    end

    always_ff @(posedge clk50mhz or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_inc_q    <= '0;
            s1_thr_q    <= '0;
            s1_rest_q   <= 1'b0;
            pend_note_q <= '{default: '0};
            pend_mult_q <= '{default: '0};
            pend_duty_q <= '{default: '0};
            pend_dir_q  <= '0;
            act_note_q  <= '{default: '0};
            act_mult_q  <= '{default: '0};
            act_duty_q  <= '{default: '0};
            act_dir_q   <= '0;
            acc_q       <= '{default: '0};
            wave_q      <= '0;
            mix_q       <= '0;
        end else begin
            slot_q      <= slot_d;
            s1_vld_q    <= 1'b1;
            s1_ch_q     <= slot_q;
            s1_inc_q    <= inc_adj;
            s1_thr_q    <= duty_thresh(act_duty_q[slot_q]);
            s1_rest_q   <= (act_note_q[slot_q] == NOTE_W'(NOTE_REST));
            pend_note_q <= pend_note_d;
            pend_mult_q <= pend_mult_d;
            pend_duty_q <= pend_duty_d;
            pend_dir_q  <= pend_dir_d;
            act_note_q  <= act_note_d;
            act_mult_q  <= act_mult_d;
            act_duty_q  <= act_duty_d;
            act_dir_q   <= act_dir_d;
            acc_q       <= acc_d;
            wave_q      <= wave_d;
            mix_q       <= MIX_W'($countones(wave_q));
        end
    end

    assign bus.wave_out = wave_q;
    assign bus.mix_out  = mix_q;
endmodule

// File: tb/tb_pulse_voice_bank.sv
// Bench for pulse_voice_bank: randomized settings checked cycle by cycle
// against a phase/frequency reference model.
module tb_pulse_voice_bank;
  localparam int N  = 4;
  localparam int NW = 6;
  localparam int AW = 24;
  localparam int OW = 3;
  localparam int MW = $clog2(N + 1);
  localparam longint MOD = 64'd1 << AW;

  typedef struct {
    int note;
    int mult;
    int dir;
    int duty;
  } set_t;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  pulse_voice_bank_if #(.NUM_CH(N), .NOTE_W(NW), .OFFS_W(OW)) bus ();

  pulse_voice_bank #(
    .NUM_CH (N),
    .NOTE_W (NW),
    .ACC_W  (AW),
    .OFFS_W (OW)
  ) dut (
    .clk50mhz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  set_t drv [N];
  set_t pend [N];
  set_t act [N];
  longint phase [N];
  logic [N-1:0] exp_wave;
  int edge_n;
  logic found;

  // Reference pitch: 55 Hz * 2^((n-1)/12), expressed as phase steps per update.
  function automatic longint base_inc(int note);
    real f;
    if (note == 0) return 0;
    f = 55.0 * (2.0 ** ((note - 1) / 12.0));
    return longint'($rtoi(f * real'(MOD) / (50.0e6 / N) + 0.5));
  endfunction

  function automatic longint adj_inc(set_t s);
    longint b;
    longint d;
    b = base_inc(s.note);
    d = (b / 128) * s.mult;
    return (s.dir != 0) ? (b - d) : (b + d);
  endfunction

  function automatic longint high_limit(int duty);
    real fr;
    case (duty)
      0:       fr = 0.125;
      1:       fr = 0.25;
      2:       fr = 0.5;
      default: fr = 0.75;
    endcase
    return longint'($rtoi(fr * real'(MOD)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d got=%0d exp=%0d", tag, edge_n, obs, exp);
    end
  endtask

  task automatic rand_set(input int k, input int lo, input int hi);
    drv[k].note = int'($urandom_range(hi, lo));
    drv[k].mult = int'($urandom_range(7, 0));
    drv[k].dir  = int'($urandom_range(1, 0));
    drv[k].duty = int'($urandom_range(3, 0));
  endtask

  task automatic drive_settings(input logic do_load);
    for (int k = 0; k < N; k++) begin
      bus.note_in[k*NW +: NW]     = NW'(drv[k].note);
      bus.offset_mult[k*OW +: OW] = OW'(drv[k].mult);
      bus.offset_dir[k]           = drv[k].dir[0];
      bus.duty_sel[k*2 +: 2]      = drv[k].duty[1:0];
    end
    bus.load = do_load;
  endtask

  function automatic logic will_wrap0();
    int nxt_edge;
    nxt_edge = edge_n + 1;
    if (nxt_edge < 2 || ((nxt_edge - 2) % N) != 0) return 1'b0;
    if (!bus.ch_en[0] || act[0].note == 0) return 1'b0;
    return (phase[0] + adj_inc(act[0])) >= MOD;
  endfunction

  // One clock: the model applies what the DUT sampled at this edge, then both
  // outputs are compared 1 ns later.
  task automatic step();
    logic [N-1:0] en_s;
    logic         ld_s;
    set_t         ld_v [N];
    int           ch;
    longint       nxt;
    logic [MW-1:0] exp_mix;
    en_s = bus.ch_en;
    ld_s = bus.load;
    ld_v = drv;
    @(posedge clk);
    edge_n++;
    exp_mix = MW'($countones(exp_wave));
    if (ld_s) pend = ld_v;
    if (edge_n >= 2) begin
      ch = (edge_n - 2) % N;
      if (!en_s[ch]) begin
        phase[ch]    = 0;
        exp_wave[ch] = 1'b0;
        act[ch]      = pend[ch];
      end else if (act[ch].note == 0) begin
        exp_wave[ch] = 1'b0;
        act[ch]      = pend[ch];
      end else begin
        nxt          = phase[ch] + adj_inc(act[ch]);
        phase[ch]    = nxt % MOD;
        exp_wave[ch] = (phase[ch] < high_limit(act[ch].duty));
        if (nxt >= MOD) act[ch] = pend[ch];
      end
    end
    #1;
    chk("wave_out", 64'(bus.wave_out), 64'(exp_wave));
    chk("mix_out", 64'(bus.mix_out), 64'(exp_mix));
  endtask

  task automatic do_reset();
    #4 rst = 1'b1;
    #1;
    chk("rst_wave_async", 64'(bus.wave_out), 64'd0);
    chk("rst_mix_async", 64'(bus.mix_out), 64'd0);
    bus.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wave_hold", 64'(bus.wave_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    edge_n   = 0;
    exp_wave = '0;
    for (int k = 0; k < N; k++) begin
      phase[k] = 0;
      pend[k]  = '{default: 0};
      act[k]   = '{default: 0};
    end
  endtask

  initial begin
    rst             = 1'b0;
    bus.note_in     = '0;
    bus.offset_mult = '0;
    bus.offset_dir  = '0;
    bus.duty_sel    = '0;
    bus.ch_en       = '0;
    bus.load        = 1'b0;
    edge_n          = 0;
    exp_wave        = '0;
    found           = 1'b0;
    for (int k = 0; k < N; k++) drv[k] = '{default: 0};
    do_reset();

    // Every duty setting on its own channel, random pitches and detunes.
    bus.ch_en = '1;
    for (int k = 0; k < N; k++) begin
      rand_set(k, 56, 63);
      drv[k].duty = k;
    end
    drv[0].note = int'($urandom_range(63, 60));
    drive_settings(1'b1);
    step();
    bus.load = 1'b0;
    repeat (6000) step();

    // Mid-period reload: channel 0 must hold its old pitch until the next wrap.
    for (int k = 1; k < N; k++) rand_set(k, 56, 63);
    rand_set(0, 60, 60);
    drive_settings(1'b1);
    step();
    bus.load = 1'b0;

    // Load landing on channel 0's wrap must be taken at that same wrap.
    for (int i = 0; i < 35000 && !found; i++) begin
      if (will_wrap0()) begin
        for (int k = 1; k < N; k++) rand_set(k, 56, 63);
        rand_set(0, 63, 63);
        drive_settings(1'b1);
        step();
        bus.load = 1'b0;
        found = 1'b1;
      end else begin
        step();
      end
    end
    chk("wrap_load_seen", 64'(found), 64'd1);
    repeat (6000) step();

    // Rest freezes channel 1's phase; it resumes from there on the next note.
    drv[1].note = 0;
    drive_settings(1'b1);
    step();
    bus.load = 1'b0;
    repeat (300) step();
    drv[1].note = 62;
    drive_settings(1'b1);
    step();
    bus.load = 1'b0;
    repeat (3000) step();

    // Disable/re-enable, then short random enable patterns across pipeline stages.
    bus.ch_en[2] = 1'b0;
    repeat (40) step();
    bus.ch_en[2] = 1'b1;
    repeat (500) step();
    for (int i = 0; i < 20; i++) begin
      bus.ch_en = N'($urandom_range((1 << N) - 1, 0));
      repeat ($urandom_range(6, 1)) step();
    end
    bus.ch_en = '1;
    repeat (2000) step();

    // Reset mid-run, then fresh settings from slot 0.
    do_reset();
    repeat (200) step();
    for (int k = 0; k < N; k++) rand_set(k, 58, 63);
    drive_settings(1'b1);
    step();
    bus.load = 1'b0;
    repeat (3000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
